// File: rtl/sram_arbiter_pkg.sv
// Shared types for the sram request/stall bus arbiter.
package sram_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int MAX_MASTERS = 8;
    localparam int BUS_ADDR_W  = 32;
    localparam int BUS_IDX_W   = $clog2(MAX_MASTERS);

    // Master index width; a single-master build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                  vld;
        logic [BUS_IDX_W-1:0]  master;
        logic [BUS_ADDR_W-1:0] addr;
    } bus_error_t;

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Cyclic priority select: first set bit of req at or after ptr.
// Latency: combinational.
// Backpressure: none; vld low when no request is pending.
module rr_pick
    import sram_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    localparam int IDX_W = idx_width(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     idx,
    output logic                 vld
);

    int j;

    // Walk the ring backwards so the nearest requester after ptr is written last.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        j   = 0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_MASTERS) begin
                j = j - N_MASTERS;
            end
            if (req[j]) begin
                idx = IDX_W'(j);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// N-master to 1-slave sram bus arbiter with round-robin grant and stall watchdog.
// Latency: one cycle IDLE->grant; zero-bubble regrant on completion.
// Backpressure: losers see m_stall=m_en; owner sees s_stall until done or aborted.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_MASTERS-1:0]                 m_en,
    input  logic [N_MASTERS-1:0][DATA_W/8-1:0]   m_we,
    input  logic [N_MASTERS-1:0][ADDR_W-1:0]     m_addr,
    input  logic [N_MASTERS-1:0][DATA_W-1:0]     m_data_w,
    output logic [N_MASTERS-1:0][DATA_W-1:0]     m_data_r,
    output logic [N_MASTERS-1:0]                 m_stall,
    output logic [N_MASTERS-1:0]                 m_err,
    output logic                                 s_en,
    output logic [DATA_W/8-1:0]                  s_we,
    output logic [ADDR_W-1:0]                    s_addr,
    output logic [DATA_W-1:0]                    s_data_w,
    input  logic [DATA_W-1:0]                    s_data_r,
    input  logic                                 s_stall,
    output logic [ADDR_W-1:0]                    err_addr
);

    localparam int IDX_W = idx_width(N_MASTERS);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_MASTERS - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] gnt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_inc;
    logic [IDX_W-1:0] pick_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic [WD_W-1:0]  wd_cnt;
    logic             busy;
    logic             gnt_en;
    logic             abort;
    logic             done;

    assign busy     = (state == BUSY);
    assign gnt_en   = m_en[gnt];
    assign gnt_inc  = (gnt == LAST) ? '0 : gnt + IDX_W'(1);
    assign abort    = busy && (TIMEOUT != 0) && (wd_cnt == WD_MAX);
    assign done     = abort || (busy && gnt_en && !s_stall);
    // On completion the next winner is searched from just past the finishing owner.
    assign pick_ptr = busy ? gnt_inc : rr_ptr;

    rr_pick #(
        .N_MASTERS (N_MASTERS)
    ) u_pick (
        .req (m_en),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            wd_cnt   <= '0;
            err_addr <= '0;
        end else if (!busy) begin
            wd_cnt <= '0;
            if (pick_vld) begin
                gnt   <= pick_idx;
                state <= BUSY;
            end
        end else if (done) begin
            rr_ptr <= gnt_inc;
            wd_cnt <= '0;
            if (abort) begin
                err_addr <= m_addr[gnt];
            end
            if (pick_vld) begin
                gnt <= pick_idx;
            end else begin
                state <= IDLE;
            end
        end else if (!gnt_en) begin
            state  <= IDLE;
            wd_cnt <= '0;
        end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // s_en is kept apart from the s_stall-dependent logic below.
    assign s_en = busy && gnt_en && !abort;

    always_comb begin
        s_we     = '0;
        s_addr   = '0;
        s_data_w = '0;
        if (busy) begin
            s_we     = m_we[gnt];
            s_addr   = m_addr[gnt];
            s_data_w = m_data_w[gnt];
        end
    end

    always_comb begin
        m_stall  = m_en;
        m_err    = '0;
        m_data_r = '0;
        if (busy) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                m_data_r[i] = s_data_r;
            end
            m_stall[gnt] = s_stall && !abort;
            m_err[gnt]   = abort;
            if (abort) begin
                m_data_r[gnt] = '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: 4 masters, TIMEOUT=4, scoreboard of completions.
module tb_sram_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wd;
        int          life;
    } req_t;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         m_en;
    logic [N-1:0][3:0]    m_we;
    logic [N-1:0][31:0]   m_addr;
    logic [N-1:0][31:0]   m_data_w;
    logic [N-1:0][31:0]   m_data_r;
    logic [N-1:0]         m_stall;
    logic [N-1:0]         m_err;
    logic [N-1:0]         fire;
    logic                 s_en;
    logic [3:0]           s_we;
    logic [31:0]          s_addr;
    logic [31:0]          s_data_w;
    logic [31:0]          s_data_r;
    logic                 s_stall;
    logic [31:0]          err_addr;

    int           n_chk = 0;
    int           n_fail = 0;
    req_t         rq[N][$];
    exp_t         exp_q[$];
    int           stall_n = 0;
    bit           stall_forever = 0;
    int           scnt = 0;
    bit           smp_stalled = 0;
    logic [N-1:0] fire_q = '0;

    sram_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (32),
        .DATA_W    (32),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_data_w (m_data_w),
        .m_data_r (m_data_r),
        .m_stall  (m_stall),
        .m_err    (m_err),
        .s_en     (s_en),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_data_w (s_data_w),
        .s_data_r (s_data_r),
        .s_stall  (s_stall),
        .err_addr (err_addr)
    );

    function automatic logic [31:0] sdat(input logic [31:0] a);
        return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
    endfunction

    assign s_data_r = sdat(s_addr);
    assign s_stall  = s_en && (stall_forever || (scnt < stall_n));
    assign fire     = m_en & ~m_stall;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic req(input int m, input logic [31:0] a, input logic [3:0] we,
                       input logic [31:0] wd, input int life);
        req_t r;
        r.addr = a;
        r.we   = we;
        r.wd   = wd;
        r.life = life;
        rq[m].push_back(r);
    endtask

    task automatic expect_done(input int m, input logic [31:0] a, input logic [3:0] we,
                               input logic [31:0] wd, input logic [31:0] rd, input logic err);
        exp_t e;
        e.m    = m;
        e.addr = a;
        e.we   = we;
        e.wd   = wd;
        e.rd   = rd;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic rd_req(input int m, input logic [31:0] a);
        req(m, a, 4'h0, 32'h0, 0);
        expect_done(m, a, 4'h0, 32'h0, sdat(a), 1'b0);
    endtask

    function automatic bit idle_all();
        if (exp_q.size() != 0) return 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0 || m_en[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input string name);
        int k;
        k = 0;
        while (!idle_all() && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Masters and slave-stall counter advance just after each rising edge.
    initial begin
        req_t cur[N];
        int   age[N];
        bit   act[N];
        m_en     = '0;
        m_we     = '0;
        m_addr   = '0;
        m_data_w = '0;
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0;
            age[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            scnt = (rst_n && smp_stalled) ? scnt + 1 : 0;
            for (int i = 0; i < N; i++) begin
                if (act[i]) begin
                    age[i]++;
                    if (fire_q[i] || (cur[i].life > 0 && age[i] >= cur[i].life)) act[i] = 1'b0;
                end
                if (!act[i] && rq[i].size() > 0) begin
                    cur[i] = rq[i].pop_front();
                    act[i] = 1'b1;
                    age[i] = 0;
                end
                m_en[i]     = act[i];
                m_we[i]     = act[i] ? cur[i].we   : 4'h0;
                m_addr[i]   = act[i] ? cur[i].addr : 32'h0;
                m_data_w[i] = act[i] ? cur[i].wd   : 32'h0;
            end
        end
    end

    // Completion monitor: every master handshake must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            smp_stalled = s_en && s_stall;
            fire_q      = rst_n ? fire : '0;
            if (rst_n) begin
                for (int i = 0; i < N; i++) begin
                    if (fire[i]) begin
                        n_chk++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_done: master %0d addr %h", i, m_addr[i]);
                        end else begin
                            e = exp_q.pop_front();
                            if (i != e.m || s_en !== !e.err || s_addr !== e.addr || s_we !== e.we ||
                                s_data_w !== e.wd || m_data_r[i] !== e.rd || m_err[i] !== e.err) begin
                                n_fail++;
                                $display("FAIL done: got m=%0d s_en=%b addr=%h we=%h wd=%h rd=%h err=%b, expected m=%0d s_en=%b addr=%h we=%h wd=%h rd=%h err=%b",
                                         i, s_en, s_addr, s_we, s_data_w, m_data_r[i], m_err[i],
                                         e.m, !e.err, e.addr, e.we, e.wd, e.rd, e.err);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int k;
        int cnt;
        bit ok;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_req",   64'({s_en, s_we, s_addr}), 64'd0);
        check("rst_s_wdata", 64'(s_data_w), 64'd0);
        check("rst_m_ctl",   64'({m_err, m_stall}), 64'd0);
        check("rst_m_rdata", 64'(m_data_r[0] | m_data_r[1] | m_data_r[2] | m_data_r[3]), 64'd0);
        check("rst_err_addr", 64'(err_addr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two masters hammering a zero-wait slave.
        rd_req(0, 32'h0000_0100); rd_req(1, 32'h0000_0200);
        rd_req(0, 32'h0000_0104); rd_req(1, 32'h0000_0204);
        rd_req(0, 32'h0000_0108); rd_req(1, 32'h0000_0208);
        k = 0;
        while (fire == '0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("t1_latency", 64'(k), 64'd2);
        check("t1_loser_stall", 64'({m_en[1], m_stall[1]}), 64'd3);
        for (int c = 0; c < 6; c++) begin
            check("t1_b2b_seq", 64'(fire), (c % 2 == 0) ? 64'd1 : 64'd2);
            @(negedge clk);
        end
        drain("t1");

        // Three stall cycles, then data.
        stall_n = 3;
        req(0, 32'h0000_1000, 4'h0, 32'h0, 0);
        expect_done(0, 32'h0000_1000, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        cnt = 0;
        k   = 0;
        do begin
            @(negedge clk);
            if (s_en && m_stall[0]) cnt++;
            k++;
        end while (!fire[0] && k < 20);
        check("t2_stall_cycles", 64'(cnt), 64'd3);
        drain("t2");
        stall_n = 0;

        // Hung slave: watchdog abort.
        stall_forever = 1'b1;
        req(0, 32'hBFC0_0010, 4'h0, 32'h0, 0);
        expect_done(0, 32'hBFC0_0010, 4'h0, 32'h0, 32'h0, 1'b1);
        k = 0;
        while (!s_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        cnt = 1;
        while (!m_err[0] && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("t3_err_cycle", 64'(cnt), 64'd5);
        check("t3_abort_outs", 64'({s_en, m_stall[0]}), 64'd0);
        stall_forever = 1'b0;
        @(negedge clk);
        check("t3_err_addr", 64'(err_addr), 64'hBFC0_0010);
        drain("t3");
        rd_req(0, 32'h0000_2000);
        drain("t3_next");

        // Granted master withdraws; pointer must stay at master 1.
        req(1, 32'h0000_0400, 4'h0, 32'h0, 1);
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (s_en) ok = 1'b0;
        end
        check("t4_no_s_en", 64'(ok), 64'd1);
        req(0, 32'h0000_0500, 4'h0, 32'h0, 0);
        req(1, 32'h0000_0600, 4'h0, 32'h0, 0);
        expect_done(1, 32'h0000_0600, 4'h0, 32'h0, sdat(32'h0000_0600), 1'b0);
        expect_done(0, 32'h0000_0500, 4'h0, 32'h0, sdat(32'h0000_0500), 1'b0);
        drain("t4");

        // Pointer at 2 with masters 1 and 3 requesting: 3 wins, then 1.
        rd_req(1, 32'h0000_0700);
        drain("t5_setup");
        req(1, 32'h0000_0710, 4'h0, 32'h0, 0);
        req(3, 32'h0000_0720, 4'hF, 32'hCAFE_F00D, 0);
        expect_done(3, 32'h0000_0720, 4'hF, 32'hCAFE_F00D, sdat(32'h0000_0720), 1'b0);
        expect_done(1, 32'h0000_0710, 4'h0, 32'h0, sdat(32'h0000_0710), 1'b0);
        drain("t5");

        // Reset in the middle of a stalled access.
        stall_forever = 1'b1;
        rd_req(2, 32'h0000_3000);
        k = 0;
        while (!s_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_s_en", 64'(s_en), 64'd0);
        check("t6_idle_stall", 64'(m_stall), 64'h4);
        stall_forever = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_regrant", 64'({s_en, s_addr}), {31'd0, 1'b1, 32'h0000_3000});
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
